act_relu_writer: RTL and testbench

- Downstream of the 16-column accumulator bank.
- Takes each column's final conv result (valid/last/result/addr), applies optional ReLU, buffers it in a small per-column FIFO, and merges the 16 streams through a round-robin arbiter into a single output-feature-map SRAM write port.
- Pulses done once every active column has written its last result.

---
 rtl/act_relu_writer.sv | 202 ++++++++++++++++++++
 tb/tb_act_relu_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_relu_writer.sv
// act_relu_writer
//   Collects the final conv results of N_COL accumulator columns, applies an
//   optional ReLU, queues each column in its own small FIFO and merges all
//   queues into one output-feature-map SRAM write port via a round-robin
//   arbiter. Pulses done once every active column has written its last result.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i         synchronous clear of FIFOs, arbiter pointer and flags
//   relu_en_i       1 = clamp negative results to zero when they are stored
//   active_cols_i   number of columns taking part in done (0 means N_COL)
//   conv_valid_i    per-column result strobe
//   conv_last_i     per-column last-result marker
//   conv_result_i   per-column signed result
//   addr_i          per-column result index
//   wr_en_o         SRAM write strobe
//   wr_addr_o       {column index, result index}
//   wr_data_o       activated data
//   done_o          one-cycle pulse, aligned with the completing write
//   overflow_o      sticky: a result was dropped on a full FIFO
module act_relu_writer #(
    parameter int N_COL      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 8,
    parameter int AW         = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          relu_en_i,
    input  logic [4:0]                    active_cols_i,
    input  logic [N_COL-1:0]              conv_valid_i,
    input  logic [N_COL-1:0]              conv_last_i,
    input  logic [N_COL-1:0][DW-1:0]      conv_result_i,
    input  logic [N_COL-1:0][AW-1:0]      addr_i,
    output logic                          wr_en_o,
    output logic [$clog2(N_COL)+AW-1:0]   wr_addr_o,
    output logic [DW-1:0]                 wr_data_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    localparam int CW = $clog2(N_COL);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int EW = 1 + AW + DW;   // entry = {last, addr, data}

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x, input logic en);
        return (en && x[DW-1]) ? '0 : x;
    endfunction

    // Columns 0..n-1 take part in done; 0 (and anything above N_COL) means all.
    function automatic logic [N_COL-1:0] active_mask(input logic [4:0] n);
        logic [N_COL-1:0] m;
        int lim;
        lim = (n == 5'd0 || int'(n) > N_COL) ? N_COL : int'(n);
        for (int c = 0; c < N_COL; c++) begin
            m[c] = (c < lim);
        end
        return m;
    endfunction

    logic [EW-1:0]       mem_q    [N_COL][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q [N_COL];
    logic [PW-1:0]       wr_ptr_d [N_COL];
    logic [PW-1:0]       rd_ptr_q [N_COL];
    logic [PW-1:0]       rd_ptr_d [N_COL];
    logic [NW-1:0]       cnt_q    [N_COL];
    logic [NW-1:0]       cnt_d    [N_COL];
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [N_COL-1:0]    flags_q, flags_d;
    logic                wr_en_q, wr_en_d;
    logic [CW+AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]       wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                gnt_vld;
    logic [CW-1:0]       gnt_idx;
    logic [EW-1:0]       gnt_entry;
    logic [N_COL-1:0]    pop;
    logic [N_COL-1:0]    push_ok;
    logic [N_COL-1:0]    flags_set;
    logic [N_COL-1:0]    mask;

    always_comb begin
        // Round-robin search: first non-empty FIFO at or after the pointer.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_COL; i++) begin
            if (!gnt_vld && cnt_q[(int'(rr_ptr_q) + i) % N_COL] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'((int'(rr_ptr_q) + i) % N_COL);
            end
        end
        pop = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
        gnt_entry = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        mask      = active_mask(active_cols_i);

        rr_ptr_d  = rr_ptr_q;
        flags_d   = flags_q;
        flags_set = flags_q;
        wr_en_d   = gnt_vld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        push_ok   = '0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        // A full FIFO still accepts a push when it is being popped this cycle.
        for (int c = 0; c < N_COL; c++) begin
            push_ok[c] = conv_valid_i[c] && (cnt_q[c] != NW'(FIFO_DEPTH) || pop[c]);
            if (conv_valid_i[c] && !push_ok[c]) ovf_d = 1'b1;
            if (push_ok[c]) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
            if (pop[c])     rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
            cnt_d[c] = cnt_q[c] + NW'(push_ok[c]) - NW'(pop[c]);
        end

        if (gnt_vld) begin
            rr_ptr_d  = CW'((int'(gnt_idx) + 1) % N_COL);
            wr_addr_d = {gnt_idx, gnt_entry[AW+DW-1:DW]};
            wr_data_d = gnt_entry[DW-1:0];
            // Done is evaluated only on a write that carries a last marker.
            if (gnt_entry[EW-1]) begin
                flags_set[gnt_idx] = 1'b1;
                if ((flags_set & mask) == mask) begin
                    done_d  = 1'b1;
                    flags_d = '0;
                end else begin
                    flags_d = flags_set;
                end
            end
        end

        if (clear_i) begin
            push_ok   = '0;
            rr_ptr_d  = '0;
            flags_d   = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            wr_data_d = '0;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end
        end
    end

    // FIFO storage carries no reset; occupancy counters define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_COL; c++) begin
            if (push_ok[c]) begin
                mem_q[c][wr_ptr_q[c]] <= {conv_last_i[c], addr_i[c],
                                          relu(conv_result_i[c], relu_en_i)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            flags_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            flags_q   <= flags_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            for (int c = 0; c < N_COL; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_act_relu_writer.sv
// Directed bench for act_relu_writer: ReLU behaviour, write latency,
// round-robin order, overflow, done tracking, clear and asynchronous reset.
module tb_act_relu_writer;

    localparam int N_COL = 16;
    localparam int DW    = 8;
    localparam int AW    = 10;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     clear_i = 1'b0;
    logic                     relu_en_i = 1'b0;
    logic [4:0]               active_cols_i = 5'd0;
    logic [N_COL-1:0]         conv_valid_i = '0;
    logic [N_COL-1:0]         conv_last_i = '0;
    logic [N_COL-1:0][DW-1:0] conv_result_i = '0;
    logic [N_COL-1:0][AW-1:0] addr_i = '0;
    logic                     wr_en_o;
    logic [4+AW-1:0]          wr_addr_o;
    logic [DW-1:0]            wr_data_o;
    logic                     done_o;
    logic                     overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    act_relu_writer #(.N_COL(N_COL), .FIFO_DEPTH(4), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .relu_en_i     (relu_en_i),
        .active_cols_i (active_cols_i),
        .conv_valid_i  (conv_valid_i),
        .conv_last_i   (conv_last_i),
        .conv_result_i (conv_result_i),
        .addr_i        (addr_i),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        conv_valid_i = '0;
        conv_last_i  = '0;
        clear_i      = 1'b0;
    endtask

    task automatic set_col(input int c, input logic [DW-1:0] res,
                           input logic [AW-1:0] a, input logic last);
        conv_valid_i[c]  = 1'b1;
        conv_result_i[c] = res;
        addr_i[c]        = a;
        conv_last_i[c]   = last;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // Push one result on one column and check the write one cycle later.
    task automatic single(input string tag, input int c, input logic relu,
                          input logic [DW-1:0] res, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp_data);
        relu_en_i = relu;
        set_col(c, res, a, 1'b0);
        tick();
        idle();
        check_eq({tag, "_lat0"}, wr_en_o, 0);
        tick();
        check_eq({tag, "_en"}, wr_en_o, 1);
        check_eq({tag, "_addr"}, wr_addr_o, {4'(c), a});
        check_eq({tag, "_data"}, wr_data_o, exp_data);
        tick();
        check_eq({tag, "_en_off"}, wr_en_o, 0);
        check_eq({tag, "_addr_hold"}, wr_addr_o, {4'(c), a});
    endtask

    task automatic flood(input int cycles);
        relu_en_i = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            for (int c = 0; c < N_COL; c++) set_col(c, 8'(c + 16 * k), 10'(k), 1'b0);
            tick();
        end
        idle();
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_wr_en", wr_en_o, 0);
        check_eq("rst_addr", wr_addr_o, 0);
        check_eq("rst_data", wr_data_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_ovf", overflow_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ReLU and latency
        single("relu_neg", 5, 1'b1, 8'h83, 10'h12A, 8'h00);
        single("relu_pos", 5, 1'b1, 8'h7F, 10'h12A, 8'h7F);
        single("pass_neg", 5, 1'b0, 8'h83, 10'h12A, 8'h83);

        // All 16 columns at once, pointer 0 -> column order
        do_clear();
        for (int c = 0; c < N_COL; c++) set_col(c, 8'(c + 1), 10'(c * 3), 1'b0);
        tick();
        idle();
        for (int k = 0; k < N_COL; k++) begin
            tick();
            check_eq($sformatf("rr16_en%0d", k), wr_en_o, 1);
            check_eq($sformatf("rr16_addr%0d", k), wr_addr_o, {4'(k), 10'(k * 3)});
            check_eq($sformatf("rr16_data%0d", k), wr_data_o, 32'(k + 1));
        end
        tick();
        check_eq("rr16_idle", wr_en_o, 0);
        set_col(3, 8'h33, 10'h003, 1'b0);
        set_col(1, 8'h11, 10'h001, 1'b0);
        tick();
        idle();
        tick();
        check_eq("rr2_first", wr_addr_o, {4'd1, 10'h001});
        check_eq("rr2_first_d", wr_data_o, 8'h11);
        tick();
        check_eq("rr2_second", wr_addr_o, {4'd3, 10'h003});
        check_eq("rr2_second_en", wr_en_o, 1);
        tick();
        check_eq("rr2_idle", wr_en_o, 0);

        // Overflow
        do_clear();
        relu_en_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < N_COL; c++) set_col(c, 8'(k), 10'(k), 1'b0);
            tick();
            if (k == 3) check_eq("ovf_before", overflow_o, 0);
        end
        idle();
        check_eq("ovf_set", overflow_o, 1);
        for (int k = 0; k < 80; k++) tick();
        check_eq("ovf_sticky", overflow_o, 1);
        check_eq("ovf_drained", wr_en_o, 0);
        do_clear();
        check_eq("ovf_cleared", overflow_o, 0);

        // Done tracking with three active columns
        active_cols_i = 5'd3;
        set_col(0, 8'h01, 10'h010, 1'b1);
        tick(); idle(); tick();
        check_eq("done_c0_wr", wr_en_o, 1);
        check_eq("done_c0", done_o, 0);
        set_col(2, 8'h02, 10'h020, 1'b1);
        tick(); idle(); tick();
        check_eq("done_c2", done_o, 0);
        set_col(1, 8'h03, 10'h030, 1'b1);
        tick(); idle();
        check_eq("done_c1_early", done_o, 0);
        tick();
        check_eq("done_c1_addr", wr_addr_o, {4'd1, 10'h030});
        check_eq("done_c1", done_o, 1);
        tick();
        check_eq("done_pulse_end", done_o, 0);
        set_col(7, 8'h07, 10'h070, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            idle();
            check_eq($sformatf("done_c7_%0d", k), done_o, 0);
        end

        // Clear against a push and a pending pop, flags dropped
        do_clear();
        active_cols_i = 5'd2;
        set_col(0, 8'h0A, 10'h001, 1'b1);
        tick(); idle(); tick();
        check_eq("clr_c0_wr", wr_en_o, 1);
        flood(6);
        check_eq("clr_ovf_pre", overflow_o, 1);
        clear_i = 1'b1;
        set_col(4, 8'h44, 10'h004, 1'b0);
        tick();
        idle();
        check_eq("clr_wr_en", wr_en_o, 0);
        check_eq("clr_ovf", overflow_o, 0);
        check_eq("clr_addr", wr_addr_o, 0);
        tick();
        check_eq("clr_empty1", wr_en_o, 0);
        tick();
        check_eq("clr_empty2", wr_en_o, 0);
        set_col(1, 8'h0B, 10'h002, 1'b1);
        tick(); idle(); tick();
        check_eq("clr_c1_wr", wr_en_o, 1);
        check_eq("clr_flags", done_o, 0);

        // Asynchronous reset mid-stream
        do_clear();
        flood(6);
        check_eq("arst_pre_en", wr_en_o, 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_en", wr_en_o, 0);
        check_eq("arst_addr", wr_addr_o, 0);
        check_eq("arst_data", wr_data_o, 0);
        check_eq("arst_ovf", overflow_o, 0);
        check_eq("arst_done", done_o, 0);
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("arst_quiet%0d", k), wr_en_o, 0);
        end
        set_col(9, 8'h55, 10'h003, 1'b0);
        tick(); idle(); tick();
        check_eq("arst_new_en", wr_en_o, 1);
        check_eq("arst_new_addr", wr_addr_o, {4'd9, 10'h003});
        check_eq("arst_new_data", wr_data_o, 8'h55);
        tick();
        check_eq("arst_new_off", wr_en_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
